// File: rtl/gactx_pkg.sv
// Shared constants and state encoding for the GACT-X direction packer.
// Lane geometry is fixed at four direction words per output beat.
package gactx_pkg;

  localparam int PKG_NUM_DIR_BLOCK = 64;
  localparam int DIR_W             = 2 * PKG_NUM_DIR_BLOCK;
  localparam int LANES             = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_e;

endpackage

// File: rtl/gactx_sync_fifo.sv
// Show-ahead synchronous FIFO; dout is the registered head entry, zero when empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module gactx_sync_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/gactx_dir_packer.sv
// Captures a tile header on done_GACT, then packs incoming direction words four per
// beat into an output FIFO. The source cannot stall, so a full FIFO drops beats and flags it.
module gactx_dir_packer
  import gactx_pkg::*;
#(
  parameter int NUM_DIR_BLOCK = 64,
  parameter int OUT_WIDTH     = 512,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_GACT,
  input  logic [OUT_WIDTH-1:0]       tile_output,
  input  logic [31:0]                dir_out_count,
  input  logic [2*NUM_DIR_BLOCK-1:0] dir_out,
  input  logic                       dir_out_valid,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overflow,
  output logic                       proto_err
);

  localparam int DW = 2 * NUM_DIR_BLOCK;

  state_e               state_q, state_d;
  logic [31:0]          expected_q, expected_d;
  logic [31:0]          recv_q, recv_d;
  logic [1:0]           lane_q, lane_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                 overflow_q, overflow_d;
  logic                 proto_err_q, proto_err_d;

  logic                 push, pop, fifo_full, fifo_empty, final_word;
  logic [OUT_WIDTH:0]   push_data, fifo_dout;
  logic [OUT_WIDTH-1:0] beat;

  assign final_word = ((recv_q + 32'd1) == expected_q);
  assign pop        = out_ready && !fifo_empty;

  // Accumulator with the incoming word dropped into the current lane.
  always_comb begin
    beat = acc_q;
    for (int l = 0; l < LANES; l++) begin
      if (lane_q == 2'(l)) beat[l*DW +: DW] = dir_out;
    end
  end

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    recv_d      = recv_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    overflow_d  = overflow_q;
    proto_err_d = proto_err_q;
    push        = 1'b0;
    push_data   = '0;
    case (state_q)
      IDLE: begin
        if (dir_out_valid) proto_err_d = 1'b1;
        if (done_GACT) begin
          push       = 1'b1;
          push_data  = {(dir_out_count == 32'd0), tile_output};
          expected_d = dir_out_count;
          recv_d     = '0;
          lane_d     = '0;
          acc_d      = '0;
          if (dir_out_count != 32'd0) state_d = PACK;
        end
      end
      PACK: begin
        if (done_GACT) proto_err_d = 1'b1;
        if (dir_out_valid) begin
          recv_d = recv_q + 32'd1;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3 || final_word) begin
            push      = 1'b1;
            push_data = {final_word, beat};
            acc_d     = '0;
          end else begin
            acc_d = beat;
          end
          if (final_word) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      recv_q      <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      recv_q      <= recv_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  gactx_sync_fifo #(
    .WIDTH(OUT_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (push_data),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign out_data  = fifo_dout[OUT_WIDTH-1:0];
  assign out_last  = fifo_dout[OUT_WIDTH];
  assign out_valid = !fifo_empty;
  assign busy      = (state_q != IDLE);
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_gactx_dir_packer.sv
// Directed-plus-random bench for gactx_dir_packer: a tile-level reference model
// fills an expected beat queue that a negedge monitor drains as beats are accepted.
module tb_gactx_dir_packer;

  localparam int NDB   = 64;
  localparam int DW    = 2 * NDB;
  localparam int OW    = 512;
  localparam int DEPTH = 8;

  typedef logic [OW:0] wide_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          done_GACT;
  logic [OW-1:0] tile_output;
  logic [31:0]   dir_out_count;
  logic [DW-1:0] dir_out;
  logic          dir_out_valid;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          overflow;
  logic          proto_err;

  always #5 clk = ~clk;

  gactx_dir_packer #(
    .NUM_DIR_BLOCK(NDB),
    .OUT_WIDTH    (OW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .done_GACT    (done_GACT),
    .tile_output  (tile_output),
    .dir_out_count(dir_out_count),
    .dir_out      (dir_out),
    .dir_out_valid(dir_out_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .overflow     (overflow),
    .proto_err    (proto_err)
  );

  int    errors = 0;
  int    checks = 0;
  int    beats_seen = 0;
  wide_t exp_q[$];
  logic  exp_overflow = 1'b0;
  logic  exp_proto = 1'b0;

  task automatic check(input string tag, input wide_t obs, input wide_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest modelled beat.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", wide_t'(out_valid), wide_t'(0));
      end else begin
        check("beat", {out_last, out_data}, exp_q.pop_front());
      end
    end
  end

  function automatic logic [OW-1:0] rand_wide();
    logic [OW-1:0] r;
    for (int i = 0; i < OW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_dir();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model FIFO: with out_ready low nothing leaves, so queue size is the occupancy.
  task automatic model_push(input wide_t e);
    if (exp_q.size() >= DEPTH) exp_overflow = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_done(input logic [OW-1:0] hdr, input logic [31:0] cnt, input bit accepted);
    done_GACT     = 1'b1;
    tile_output   = hdr;
    dir_out_count = cnt;
    step();
    done_GACT = 1'b0;
    if (accepted) model_push({(cnt == 32'd0), hdr});
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    dir_out       = w;
    dir_out_valid = 1'b1;
    step();
    dir_out_valid = 1'b0;
  endtask

  // One tile: header, then cnt words spaced gap cycles apart; optionally a
  // stray done_GACT just before word inject_at.
  task automatic run_tile(input int cnt, input int gap, input int inject_at);
    logic [OW-1:0] acc;
    logic [DW-1:0] w;
    acc = '0;
    send_done(rand_wide(), 32'(cnt), 1'b1);
    for (int i = 0; i < cnt; i++) begin
      if (i == inject_at) begin
        send_done(rand_wide(), 32'd3, 1'b0);
        exp_proto = 1'b1;
      end
      if (gap > 1) idle(gap - 1);
      w = rand_dir();
      send_word(w);
      acc[(i % 4)*DW +: DW] = w;
      if ((i % 4) == 3 || i == cnt - 1) begin
        model_push({(i == cnt - 1), acc});
        acc = '0;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    check(tag, wide_t'(exp_q.size()), wide_t'(0));
    idle(2);
    check({tag, "_valid_low"}, wide_t'(out_valid), wide_t'(0));
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_overflow"}, wide_t'(overflow), wide_t'(exp_overflow));
    check({tag, "_proto_err"}, wide_t'(proto_err), wide_t'(exp_proto));
  endtask

  initial begin
    int seen0;
    rst           = 1'b1;
    done_GACT     = 1'b0;
    tile_output   = '0;
    dir_out_count = '0;
    dir_out       = '0;
    dir_out_valid = 1'b0;
    out_ready     = 1'b1;
    idle(2);
    check("rst_out_valid", wide_t'(out_valid), wide_t'(0));
    check("rst_out_last", wide_t'(out_last), wide_t'(0));
    check("rst_out_data", wide_t'(out_data), wide_t'(0));
    check("rst_busy", wide_t'(busy), wide_t'(0));
    check_flags("rst");
    rst = 1'b0;
    idle(2);

    // Zero directions: header only, last set, FSM never leaves IDLE.
    send_done(rand_wide(), 32'd0, 1'b1);
    check("zero_busy", wide_t'(busy), wide_t'(0));
    wait_drain("zero_drain");

    // Partial final beat: five words, one every three cycles.
    run_tile(5, 3, -1);
    wait_drain("partial_drain");

    // Exact multiple, back-to-back words; also check busy mid-tile.
    send_done(rand_wide(), 32'd8, 1'b1);
    check("exact_busy", wide_t'(busy), wide_t'(1));
    begin
      logic [OW-1:0] acc;
      logic [DW-1:0] w;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
        w = rand_dir();
        send_word(w);
        acc[(i % 4)*DW +: DW] = w;
        if ((i % 4) == 3) begin
          model_push({(i == 7), acc});
          acc = '0;
        end
      end
    end
    check("exact_busy_end", wide_t'(busy), wide_t'(0));
    wait_drain("exact_drain");

    // Random tiles with random spacing and occasional downstream stalls.
    for (int t = 0; t < 6; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      run_tile($urandom_range(1, 9), $urandom_range(1, 3), -1);
      out_ready = 1'b1;
      wait_drain("rand_drain");
    end
    check_flags("rand");

    // Stray dir_out_valid in IDLE.
    send_word(rand_dir());
    exp_proto = 1'b1;
    idle(2);
    check_flags("proto_idle");
    check("proto_idle_valid", wide_t'(out_valid), wide_t'(0));
    check("proto_idle_busy", wide_t'(busy), wide_t'(0));

    // Stray done_GACT mid-tile must not disturb the tile in flight.
    run_tile(6, 2, 2);
    wait_drain("proto_pack_drain");
    check_flags("proto_pack");

    // Backpressure: 11 beats into an 8-deep FIFO with no draining.
    out_ready = 1'b0;
    run_tile(40, 1, -1);
    idle(2);
    check("bp_model_overflow", wide_t'(exp_overflow), wide_t'(1));
    check_flags("bp");
    check("bp_valid", wide_t'(out_valid), wide_t'(1));
    seen0 = beats_seen;
    out_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_drained_count", wide_t'(beats_seen - seen0), wide_t'(DEPTH));

    // Reset partway through a tile discards the header and partial words.
    out_ready = 1'b0;
    send_done(rand_wide(), 32'd5, 1'b1);
    send_word(rand_dir());
    send_word(rand_dir());
    check("mid_busy", wide_t'(busy), wide_t'(1));
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_overflow = 1'b0;
    exp_proto    = 1'b0;
    check("mid_rst_valid", wide_t'(out_valid), wide_t'(0));
    check("mid_rst_busy", wide_t'(busy), wide_t'(0));
    check_flags("mid_rst");
    idle(2);
    rst = 1'b0;
    out_ready = 1'b1;
    seen0 = beats_seen;
    run_tile(1, 3, -1);
    wait_drain("post_rst_drain");
    check("post_rst_count", wide_t'(beats_seen - seen0), wide_t'(2));
    check_flags("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
